// File: rtl/i2c_write_arbiter_if.sv
// Signal bundle between i2c_write_arbiter and its two requesters plus the shared byte engine.
// master = arbiter side; slave = requesters and engine side.
interface i2c_write_arbiter_if;
   logic       req0, req1;
   logic [7:0] addr0, reg0, data0;
   logic [7:0] addr1, reg1, data1;
   logic       done0, done1;
   logic [7:0] status0, status1;
   logic       err0, err1;
   logic [7:0] eng_address, eng_register, eng_data;
   logic       eng_enable_send;
   logic       eng_busy;
   logic [7:0] eng_status;
   logic       grant;
   logic       arb_busy;

   modport master (
      input  req0, req1, addr0, reg0, data0, addr1, reg1, data1, eng_busy, eng_status,
      output done0, done1, status0, status1, err0, err1,
             eng_address, eng_register, eng_data, eng_enable_send, grant, arb_busy
   );

   modport slave (
      output req0, req1, addr0, reg0, data0, addr1, reg1, data1, eng_busy, eng_status,
      input  done0, done1, status0, status1, err0, err1,
             eng_address, eng_register, eng_data, eng_enable_send, grant, arb_busy
   );
endinterface

// File: rtl/i2c_write_arbiter.sv
// Round-robin sharing of one i2c_master_write_byte engine between two register-write requesters.
// Define I2C_ARB_RETRY_EN to retry NACKed transfers up to MAX_RETRY extra times.
module i2c_write_arbiter #(
   parameter int MAX_RETRY     = 2,
   parameter int START_TIMEOUT = 4096
) (
   input  logic                clock,
   input  logic                reset,
   i2c_write_arbiter_if.master bus
);

   typedef enum logic [2:0] {IDLE, START, RUN, CHECK, DONE, FAIL} state_t;

   localparam logic [7:0]  ACK_MASK     = 8'h2A;
   localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        busy_p0, busy_p1;
   logic        last_served;
   logic        pick;
   logic        grant_q;
   logic [15:0] tmo_cnt;
   logic [7:0]  eng_address_q, eng_register_q, eng_data_q;
   logic [7:0]  status0_q, status1_q;
   logic        err0_q, err1_q;
   logic [7:0]  fin_status;
   logic        retry_ok;

   function automatic logic ack_ok(input logic [7:0] st);
      return (st & ACK_MASK) == ACK_MASK;
   endfunction

`ifdef I2C_ARB_RETRY_EN
   logic [2:0] retry_cnt;

   assign retry_ok = retry_cnt < 3'(MAX_RETRY);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         retry_cnt <= 3'd0;
      else if (state == IDLE)
         retry_cnt <= 3'd0;
      else if (state == CHECK && state_nxt == START)
         retry_cnt <= retry_cnt + 3'd1;
   end
`else
   // Retry depth has no effect when every grant makes a single attempt.
   logic [2:0] unused_max_retry;

   assign unused_max_retry = 3'(MAX_RETRY);
   assign retry_ok         = 1'b0;
`endif

   // Stage p0/p1: two-flop synchronizer, busy_p1 is busy_s (1 = engine idle).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_p0 <= 1'b1;
         busy_p1 <= 1'b1;
      end else begin
         busy_p0 <= bus.eng_busy;
         busy_p1 <= busy_p0;
      end
   end

   always_comb begin
      pick = 1'b0;
      if (bus.req0 && bus.req1)
         pick = ~last_served;
      else if (bus.req1)
         pick = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.req0 || bus.req1) state_nxt = START;
         START: begin
            if (!busy_p1)
               state_nxt = RUN;
            else if (tmo_cnt == TIMEOUT_LAST)
               state_nxt = FAIL;
         end
         RUN:   if (busy_p1) state_nxt = CHECK;
         CHECK: begin
            if (ack_ok(bus.eng_status))
               state_nxt = DONE;
            else if (retry_ok)
               state_nxt = START;
            else
               state_nxt = FAIL;
         end
         DONE, FAIL: state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.eng_enable_send = (state != START);
      bus.arb_busy        = (state != IDLE);
      bus.done0           = (state == DONE || state == FAIL) && !grant_q;
      bus.done1           = (state == DONE || state == FAIL) && grant_q;
   end

   // A timeout reaches FAIL from START and reports no engine status.
   assign fin_status = (state == CHECK) ? bus.eng_status : 8'h00;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant_q        <= 1'b0;
         last_served    <= 1'b1;
         tmo_cnt        <= 16'd0;
         eng_address_q  <= 8'h00;
         eng_register_q <= 8'h00;
         eng_data_q     <= 8'h00;
         status0_q      <= 8'h00;
         status1_q      <= 8'h00;
         err0_q         <= 1'b0;
         err1_q         <= 1'b0;
      end else begin
         if (state == IDLE && state_nxt == START) begin
            grant_q        <= pick;
            eng_address_q  <= pick ? bus.addr1 : bus.addr0;
            eng_register_q <= pick ? bus.reg1  : bus.reg0;
            eng_data_q     <= pick ? bus.data1 : bus.data0;
         end

         if (state == START)
            tmo_cnt <= tmo_cnt + 16'd1;
         else
            tmo_cnt <= 16'd0;

         if (state_nxt == DONE || state_nxt == FAIL) begin
            if (grant_q) begin
               status1_q <= fin_status;
               err1_q    <= (state_nxt == FAIL);
            end else begin
               status0_q <= fin_status;
               err0_q    <= (state_nxt == FAIL);
            end
         end

         if (state == DONE || state == FAIL)
            last_served <= grant_q;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.eng_address  = eng_address_q;
   assign bus.eng_register = eng_register_q;
   assign bus.eng_data     = eng_data_q;
   assign bus.status0      = status0_q;
   assign bus.status1      = status1_q;
   assign bus.err0         = err0_q;
   assign bus.err1         = err1_q;

endmodule
